seq_detect_arbiter: RTL and testbench
=====================================

Name: seq_detect_arbiter

Overview:
Shares one serial sequence detector between two serial bit sources. Grants the detector to one source at a time for a fixed-length frame, using round-robin order. Clears the detector before each frame and drains late success pulses after it. Keeps a saturating match count for each source and pulses done at the end of every frame. Sits between the stimulus sources and the detector FSM in the lab top level.

Parameters:
FRAME_LEN, 8, serial bits streamed per granted frame (2..63)
DRAIN_CYC, 2, cycles after the last bit during which det_success is still credited to the owner (1..7)
CNT_W, 6, width of each match counter (matches the detector's count width)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
req0  in  1  source 0 requests a frame; held high until done
req1  in  1  source 1 requests a frame
bit0  in  1  serial data from source 0, sampled every STREAM cycle while grant0=1
bit1  in  1  serial data from source 1
grant0  out  1  high during STREAM while source 0 owns the detector
grant1  out  1  high during STREAM while source 1 owns the detector
det_clear  out  1  one-cycle synchronous clear pulse to the detector
det_input  out  1  serial bit to the detector (sequential_input)
det_success  in  1  detector success output
clear_counts  in  1  synchronous clear of both match counters
match_count0  out  CNT_W  saturating success count for source 0
match_count1  out  CNT_W  saturating success count for source 1
done  out  1  one-cycle pulse in RELEASE
done_id  out  1  owner of the frame that just finished; valid with done
aborted  out  1  valid with done; 1 if the frame was truncated
state  out  3  current arbiter state, for debug and bench

Behaviour:
- Reset values: state=IDLE; grants, det_clear, det_input, done, done_id, aborted all 0; both counters 0; owner=0; last_served=1, so source 0 wins first.
- States and encodings: IDLE 000, CLEAR 001, STREAM 011, DRAIN 010, RELEASE 110. Any other encoding returns to IDLE on the next clock.
- IDLE:
  - Single request: that source becomes owner.
  - Both requesting: owner = ~last_served.
  - Any request: go to CLEAR next cycle. No request: stay in IDLE.
- CLEAR: det_clear=1 for exactly one cycle; bit counter loads 0; go to STREAM.
- STREAM:
  - grant_owner=1 and det_input = bit_owner (combinational pass-through). det_input=0 in every other state.
  - Bit counter increments each cycle.
  - After FRAME_LEN STREAM cycles, go to DRAIN.
  - If req_owner drops in STREAM, that cycle's bit is not passed (det_input=0), aborted flag is set, and the block goes to DRAIN next cycle.
- DRAIN: det_input=0; no grant; stays exactly DRAIN_CYC cycles; then go to RELEASE.
- Crediting: every cycle in STREAM or DRAIN with det_success=1 increments match_count[owner]. Counters saturate at 2^CNT_W-1. det_success is ignored in IDLE, CLEAR and RELEASE.
- RELEASE: done=1, done_id=owner, aborted=flag; last_served<=owner; flag cleared; go to IDLE.
- Latency: request sampled at edge k gives CLEAR at k+1, STREAM k+2..k+1+FRAME_LEN, DRAIN for DRAIN_CYC cycles, then RELEASE, then IDLE. With the defaults, RELEASE is at k+12 and IDLE at k+13.
- A request held through RELEASE is re-arbitrated in IDLE, so IDLE always lasts at least one cycle between frames.
- clear_counts coinciding with an increment: clear wins, and the counter is 0 next cycle.
- Reset asserted mid-frame: immediate return to reset values. No done pulse is issued, and the counts are lost.

Decomposition:
- Shared package: the state encodings above (the lab's 3-bit Gray-style convention), the FRAME_LEN and DRAIN_CYC defaults, and CNT_W.
- One natural sub-module: sat_counter, a CNT_W-bit counter with inc, sync clear (clear priority) and saturation. Instantiate it twice.

Test Plan:
- Bench detector stub: pulses det_success one cycle after the third consecutive 1.
- Reset, then req0 held with bit0 = 0,1,1,1,0,1,1,1: CLEAR at k+1, grant0 high for 8 cycles, count0=2, done at k+12 with done_id=0 and aborted=0.
- req0 and req1 raised in the same cycle after reset: source 0 served first, source 1 second. IDLE occurs between the two frames; the second done has done_id=1.
- Source 1 sends 1 at 0,0,0,0,0,1,1,1: the last match is credited in DRAIN, giving count1=1.
- Source 0 sends all ones over 32 frames: count0 saturates at 63, then stays 63. Asserting clear_counts in a success cycle gives 0 on the next cycle.
- req0 dropped after the 3rd STREAM cycle: next state DRAIN, then done with aborted=1. last_served=0, so the pending req1 is served next.
- reset asserted mid-STREAM: grant0, det_input and counts go to 0 asynchronously, state=000, and no done pulse occurs.

Source files
------------

// File: rtl/seq_detect_arbiter_pkg.sv
// Shared definitions for the two-source sequence-detector arbiter:
// state encodings (3-bit Gray-style) and parameter defaults.
package seq_detect_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_CLEAR   = 3'b001,
        ST_STREAM  = 3'b011,
        ST_DRAIN   = 3'b010,
        ST_RELEASE = 3'b110
    } arb_state_e;

    localparam int FRAME_LEN_DEF = 8;
    localparam int DRAIN_CYC_DEF = 2;
    localparam int CNT_W_DEF     = 6;

endpackage

// File: rtl/seq_detect_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import seq_detect_arbiter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter that lends one serial sequence detector to two bit
// sources, one fixed-length frame at a time, and tallies matches per source.
module seq_detect_arbiter
    import seq_detect_arbiter_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             bit0,
    input  logic             bit1,
    output logic             grant0,
    output logic             grant1,
    output logic             det_clear,
    output logic             det_input,
    input  logic             det_success,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] match_count0,
    output logic [CNT_W-1:0] match_count1,
    output logic             done,
    output logic             done_id,
    output logic             aborted,
    output logic [2:0]       state
);

    localparam int BC_W = 6;
    localparam int DC_W = 3;
    localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(FRAME_LEN - 1);
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYC - 1);

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            abort_q, abort_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
    logic            req_own;
    logic            bit_own;
    logic            credit;

    assign req_own = owner_q ? req1 : req0;
    assign bit_own = owner_q ? bit1 : bit0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            abort_q     <= 1'b0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            abort_q     <= abort_d;
            bit_cnt_q   <= bit_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        abort_d     = abort_q;
        bit_cnt_d   = bit_cnt_q;
        drain_cnt_d = drain_cnt_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        det_clear   = 1'b0;
        det_input   = 1'b0;
        done        = 1'b0;
        done_id     = 1'b0;
        aborted     = 1'b0;
        credit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    owner_d = ~last_q;
                    state_d = ST_CLEAR;
                end else if (req0) begin
                    owner_d = 1'b0;
                    state_d = ST_CLEAR;
                end else if (req1) begin
                    owner_d = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                det_clear = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                grant0      = ~owner_q;
                grant1      = owner_q;
                credit      = det_success;
                bit_cnt_d   = bit_cnt_q + BC_W'(1);
                drain_cnt_d = '0;
                // An owner that withdraws mid-frame forfeits the current bit.
                if (!req_own) begin
                    abort_d = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    det_input = bit_own;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                credit      = det_success;
                drain_cnt_d = drain_cnt_q + DC_W'(1);
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                done    = 1'b1;
                done_id = owner_q;
                aborted = abort_q;
                last_d  = owner_q;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_count0 (
        .clk_i  (clock),
        .rst_i  (reset),
        .inc_i  (credit & ~owner_q),
        .clr_i  (clear_counts),
        .count_o(match_count0)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_count1 (
        .clk_i  (clock),
        .rst_i  (reset),
        .inc_i  (credit & owner_q),
        .clr_i  (clear_counts),
        .count_o(match_count1)
    );

    assign state = state_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Bench for seq_detect_arbiter: two frame-driven bit sources, a "111"
// detector stub, and a frame-level model of arbitration and match counting.
module tb_seq_detect_arbiter;
    import seq_detect_arbiter_pkg::*;

    localparam int FL   = 8;
    localparam int DC   = 2;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MAXF = 40;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, bit0 = 1'b0, bit1 = 1'b0;
    logic          clear_counts = 1'b0;
    logic          det_success;
    logic          grant0, grant1, det_clear, det_input, done, done_id, aborted;
    logic [CW-1:0] match_count0, match_count1;
    logic [2:0]    state;

    seq_detect_arbiter #(.FRAME_LEN(FL), .DRAIN_CYC(DC), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .bit0(bit0), .bit1(bit1), .grant0(grant0), .grant1(grant1),
        .det_clear(det_clear), .det_input(det_input), .det_success(det_success),
        .clear_counts(clear_counts), .match_count0(match_count0),
        .match_count1(match_count1), .done(done), .done_id(done_id),
        .aborted(aborted), .state(state)
    );

    always #5 clock = ~clock;

    // Detector stub: success one cycle after the third consecutive 1.
    logic [1:0] run_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q       <= 2'd0;
            det_success <= 1'b0;
        end else if (det_clear) begin
            run_q       <= 2'd0;
            det_success <= 1'b0;
        end else begin
            det_success <= det_input && run_q[1];
            if (!det_input)          run_q <= 2'd0;
            else if (run_q != 2'd3)  run_q <= run_q + 2'd1;
        end
    end

    logic [FL-1:0] pats   [2][MAXF];
    int            aborts [2][MAXF];
    int            nframes [2];
    int            fidx    [2];
    int            idx     [2];
    logic          req_v   [2];
    logic          bit_v   [2];
    int            n_checks;
    int            n_pass;

    function automatic int triples(input logic [FL-1:0] p, input int n);
        int c;
        c = 0;
        for (int i = 2; i < n; i++) begin
            if (p[i] && p[i-1] && p[i-2]) c++;
        end
        return c;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic apply();
        req0 = req_v[0];
        req1 = req_v[1];
        bit0 = bit_v[0];
        bit1 = bit_v[1];
    endtask

    task automatic reset_model();
        for (int s = 0; s < 2; s++) begin
            nframes[s] = 0;
            fidx[s]    = 0;
            idx[s]     = 0;
            req_v[s]   = 1'b0;
            bit_v[s]   = 1'b0;
        end
        apply();
    endtask

    // One clock: sources react to what they see, then outputs settle.
    task automatic tick();
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            logic g;
            g = (s == 0) ? grant0 : grant1;
            bit_v[s] = 1'($urandom);
            if (done && (done_id == s[0])) begin
                fidx[s]++;
                idx[s]   = 0;
                req_v[s] = (fidx[s] < nframes[s]);
            end else if ((state == ST_STREAM) && g) begin
                bit_v[s] = pats[s][fidx[s]][idx[s]];
                if (idx[s] == aborts[s][fidx[s]]) req_v[s] = 1'b0;
                idx[s]++;
            end
        end
        apply();
        #2;
    endtask

    task automatic do_reset();
        reset_model();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (state == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_model();
        reset = 1'b1;
        tick();
        n_checks++;
        if (state !== 3'b000) $display("FAIL reset_state: got %b want 000", state); else n_pass++;
        n_checks++;
        if ({grant0, grant1, det_clear, det_input} !== 4'b0)
            $display("FAIL reset_ctrl: got %b want 0000", {grant0, grant1, det_clear, det_input});
        else n_pass++;
        n_checks++;
        if ({done, done_id, aborted} !== 3'b0)
            $display("FAIL reset_done: got %b want 000", {done, done_id, aborted});
        else n_pass++;
        n_checks++;
        if ({match_count0, match_count1} !== '0)
            $display("FAIL reset_counts: got %0d/%0d want 0/0", match_count0, match_count1);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [FL-1:0] p;
        logic [2:0]    exp_st;
        do_reset();
        p = 8'b1110_1110;
        pats[0][0] = p; aborts[0][0] = -1; nframes[0] = 1; req_v[0] = 1'b1;
        apply();
        for (int c = 1; c <= 13; c++) begin
            tick();
            exp_st = (c == 1) ? ST_CLEAR : (c <= 9) ? ST_STREAM :
                     (c <= 11) ? ST_DRAIN : (c == 12) ? ST_RELEASE : ST_IDLE;
            n_checks++;
            if (state !== exp_st) $display("FAIL single_state c=%0d: got %b want %b", c, state, exp_st);
            else n_pass++;
            n_checks++;
            if ({grant0, det_clear, done} !== {(c >= 2 && c <= 9), (c == 1), (c == 12)})
                $display("FAIL single_ctrl c=%0d: got g/clr/done=%b want %b", c, {grant0, det_clear, done},
                         {(c >= 2 && c <= 9), (c == 1), (c == 12)});
            else n_pass++;
            if (c >= 2 && c <= 9) begin
                n_checks++;
                if (det_input !== p[c-2]) $display("FAIL single_bit c=%0d: got %b want %b", c, det_input, p[c-2]);
                else n_pass++;
            end
            if (c == 12) begin
                n_checks++;
                if ({done_id, aborted} !== 2'b00) $display("FAIL single_id: got %b want 00", {done_id, aborted});
                else n_pass++;
                n_checks++;
                if (match_count0 !== CW'(triples(p, FL)))
                    $display("FAIL single_count: got %0d want %0d", match_count0, triples(p, FL));
                else n_pass++;
            end
        end
    endtask

    task automatic test_both_requests();
        bit ok;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            pats[s][0] = '0; aborts[s][0] = -1; nframes[s] = 1; req_v[s] = 1'b1;
        end
        apply();
        wait_done(30, ok);
        n_checks++;
        if (!ok || done_id !== 1'b0) $display("FAIL both_first: done=%b id=%b want id 0", ok, done_id);
        else n_pass++;
        tick();
        n_checks++;
        if (state !== 3'b000) $display("FAIL both_idle_gap: got %b want 000", state); else n_pass++;
        wait_done(30, ok);
        n_checks++;
        if (!ok || done_id !== 1'b1) $display("FAIL both_second: done=%b id=%b want id 1", ok, done_id);
        else n_pass++;
    endtask

    task automatic test_drain_credit();
        bit ok;
        do_reset();
        pats[1][0] = 8'b1110_0000; aborts[1][0] = -1; nframes[1] = 1; req_v[1] = 1'b1;
        apply();
        wait_state(ST_DRAIN, 20, ok);
        n_checks++;
        if (!ok || match_count1 !== '0 || det_success !== 1'b1)
            $display("FAIL drain_entry: reached=%b count1=%0d success=%b want 1/0/1", ok, match_count1, det_success);
        else n_pass++;
        tick();
        n_checks++;
        if (match_count1 !== CW'(1)) $display("FAIL drain_credit: got %0d want 1", match_count1); else n_pass++;
        wait_done(10, ok);
        n_checks++;
        if (!ok || done_id !== 1'b1 || match_count1 !== CW'(1) || match_count0 !== '0)
            $display("FAIL drain_done: done=%b id=%b c0=%0d c1=%0d want 1/1/0/1", ok, done_id, match_count0, match_count1);
        else n_pass++;
    endtask

    task automatic test_saturation();
        bit ok;
        int exp_c;
        do_reset();
        for (int k = 0; k < 33; k++) begin
            pats[0][k] = '1; aborts[0][k] = -1;
        end
        nframes[0] = 33; req_v[0] = 1'b1;
        apply();
        exp_c = 0;
        for (int k = 0; k < 32; k++) begin
            wait_done(30, ok);
            exp_c = sat_add(exp_c, triples('1, FL));
            n_checks++;
            if (!ok || match_count0 !== CW'(exp_c))
                $display("FAIL sat_frame%0d: done=%b got %0d want %0d", k, ok, match_count0, exp_c);
            else n_pass++;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state == ST_STREAM && det_success) begin
                ok = 1'b1;
                break;
            end
        end
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        n_checks++;
        if (!ok || match_count0 !== '0)
            $display("FAIL sat_clear: found=%b got %0d want 0", ok, match_count0);
        else n_pass++;
        wait_done(20, ok);
        // The success coinciding with the clear is lost; the rest still count.
        n_checks++;
        if (!ok || match_count0 !== CW'(triples('1, FL) - 1))
            $display("FAIL sat_after_clear: done=%b got %0d want %0d", ok, match_count0, triples('1, FL) - 1);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        logic [FL-1:0] ones;
        ones = '1;
        do_reset();
        pats[0][0] = ones; aborts[0][0] = 3;  nframes[0] = 1; req_v[0] = 1'b1;
        pats[1][0] = '0;   aborts[1][0] = -1; nframes[1] = 1; req_v[1] = 1'b1;
        apply();
        wait_state(ST_STREAM, 10, ok);
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (!ok || state !== 3'b011 || det_input !== 1'b0)
            $display("FAIL abort_mask: reached=%b state=%b det_input=%b want 1/011/0", ok, state, det_input);
        else n_pass++;
        tick();
        n_checks++;
        if (state !== 3'b010) $display("FAIL abort_drain: got %b want 010", state); else n_pass++;
        wait_done(10, ok);
        n_checks++;
        if (!ok || {done_id, aborted} !== 2'b01 || match_count0 !== CW'(triples(ones, 3)))
            $display("FAIL abort_done: done=%b id/ab=%b count0=%0d want 1/01/%0d",
                     ok, {done_id, aborted}, match_count0, triples(ones, 3));
        else n_pass++;
        wait_done(30, ok);
        n_checks++;
        if (!ok || {done_id, aborted} !== 2'b10)
            $display("FAIL abort_next: done=%b id/ab=%b want 1/10", ok, {done_id, aborted});
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int ndone;
        do_reset();
        pats[0][0] = '1; aborts[0][0] = -1; nframes[0] = 1; req_v[0] = 1'b1;
        apply();
        wait_state(ST_STREAM, 10, ok);
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (!ok || grant0 !== 1'b1 || match_count0 !== CW'(2))
            $display("FAIL midreset_pre: reached=%b grant0=%b count0=%0d want 1/1/2", ok, grant0, match_count0);
        else n_pass++;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({state, grant0, det_input, done} !== 6'b0 || match_count0 !== '0)
            $display("FAIL midreset_async: state=%b g0=%b din=%b done=%b count0=%0d want all 0",
                     state, grant0, det_input, done, match_count0);
        else n_pass++;
        reset_model();
        tick();
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) ndone++;
        end
        n_checks++;
        if (ndone !== 0 || state !== 3'b000)
            $display("FAIL midreset_quiet: dones=%0d state=%b want 0/000", ndone, state);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int rem [2];
        int expc [2];
        int exp_last, exp_id, k, n;
        logic [CW-1:0] got;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            for (int f = 0; f < 6; f++) begin
                pats[s][f]   = FL'($urandom);
                aborts[s][f] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FL - 1)) : -1;
            end
            nframes[s] = 6; rem[s] = 6; expc[s] = 0; req_v[s] = 1'b1;
        end
        apply();
        exp_last = 1;
        for (int j = 0; j < 12; j++) begin
            exp_id = (rem[0] > 0 && rem[1] > 0) ? 1 - exp_last : (rem[0] > 0) ? 0 : 1;
            k = 6 - rem[exp_id];
            n = (aborts[exp_id][k] >= 0) ? aborts[exp_id][k] : FL;
            expc[exp_id] = sat_add(expc[exp_id], triples(pats[exp_id][k], n));
            rem[exp_id]--;
            exp_last = exp_id;
            wait_done(40, ok);
            got = (exp_id == 0) ? match_count0 : match_count1;
            n_checks++;
            if (!ok || done_id !== exp_id[0])
                $display("FAIL rand_id%0d: done=%b got %b want %0d", j, ok, done_id, exp_id);
            else n_pass++;
            n_checks++;
            if (aborted !== (aborts[exp_id][k] >= 0))
                $display("FAIL rand_abort%0d: got %b want %b", j, aborted, (aborts[exp_id][k] >= 0));
            else n_pass++;
            n_checks++;
            if (got !== CW'(expc[exp_id]))
                $display("FAIL rand_count%0d: src %0d got %0d want %0d", j, exp_id, got, expc[exp_id]);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_frame();
        test_both_requests();
        test_drain_credit();
        test_saturation();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
